// File: rtl/str_gen.sv
// Stream traffic generator: framed packets with ramp/counter data, idle gaps and run limits.
// Latency: first beat is presented the cycle after an accepted start; every output is registered.
// Backpressure: a presented beat holds data/keep/last and tvalid until tready accepts it.
module str_gen #(
  parameter int DW = 32,
  parameter int LW = 16,
  parameter int GW = 8,
  parameter int CW = 16,
  localparam int BW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [LW-1:0] cfg_len,
  input  logic [GW-1:0] cfg_gap,
  input  logic [CW-1:0] cfg_cnt,
  input  logic          cfg_mode,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pkt_cnt,
  output logic          tvalid,
  input  logic          tready,
  output logic [DW-1:0] tdata,
  output logic [BW-1:0] tkeep,
  output logic          tlast
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;          // effective packet length, never 0
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [LW-1:0] rem_q, rem_d;          // bytes left after the presented beat
  logic [7:0]    off_q, off_d;          // byte offset (mod 256) of the next beat
  logic [DW-1:0] run_beat_q, run_beat_d; // beats presented so far in this run
  logic [GW-1:0] gap_ctr_q, gap_ctr_d;
  logic          stop_pend_q, stop_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tvalid_q, tvalid_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [BW-1:0] tkeep_q, tkeep_d;
  logic          tlast_q, tlast_d;

  // Beat builder inputs: where the next presented beat comes from.
  logic          ld_beat;
  logic          go_idle;
  logic          finish_c;
  logic [LW-1:0] len_c;
  logic [LW-1:0] src_rem;
  logic [7:0]    src_off;
  logic [7:0]    src_p;
  logic [DW-1:0] src_beat;
  logic          src_mode;
  logic          last_c;
  logic [LW-1:0] take_c;
  logic [DW-1:0] beat_dat;
  logic [BW-1:0] beat_keep;

  // Next-state, run control and construction of the next presented beat.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pkt_cnt_d   = pkt_cnt_q;
    rem_d       = rem_q;
    off_d       = off_q;
    run_beat_d  = run_beat_q;
    gap_ctr_d   = gap_ctr_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    ld_beat     = 1'b0;
    go_idle     = 1'b0;
    finish_c    = 1'b0;
    len_c       = (cfg_len == '0) ? LW'(1) : cfg_len;
    src_rem     = len_q;
    src_off     = '0;
    src_p       = 8'(pkt_cnt_q);
    src_beat    = run_beat_q;
    src_mode    = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = len_c;
          gap_d       = cfg_gap;
          cnt_d       = cfg_cnt;
          mode_d      = cfg_mode;
          pkt_cnt_d   = '0;
          stop_pend_d = 1'b0;
          state_d     = S_SEND;
          ld_beat     = 1'b1;
          src_rem     = len_c;
          src_p       = '0;
          src_beat    = '0;
          src_mode    = cfg_mode;
        end
      end
      S_SEND: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tvalid_q && tready) begin
          if (tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
            finish_c  = stop_pend_q || stop || ((cnt_q != '0) && (pkt_cnt_d == cnt_q));
            if (finish_c) begin
              go_idle = 1'b1;
            end else if (gap_q == '0) begin
              // Back-to-back: next packet's first beat replaces this one directly.
              ld_beat = 1'b1;
              src_p   = 8'(pkt_cnt_d);
            end else begin
              state_d   = S_GAP;
              gap_ctr_d = gap_q;
              tvalid_d  = 1'b0;
              tdata_d   = '0;
              tkeep_d   = '0;
              tlast_d   = 1'b0;
            end
          end else begin
            ld_beat = 1'b1;
            src_rem = rem_q;
            src_off = off_q;
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (gap_ctr_q == GW'(1)) begin
          state_d = S_SEND;
          ld_beat = 1'b1;
        end else begin
          gap_ctr_d = gap_ctr_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_idle) begin
      state_d     = S_IDLE;
      done_d      = 1'b1;
      stop_pend_d = 1'b0;
      tvalid_d    = 1'b0;
      tdata_d     = '0;
      tkeep_d     = '0;
      tlast_d     = 1'b0;
    end

    // A beat carries up to BW bytes; the final beat is partially filled.
    last_c    = (src_rem <= LW'(BW));
    take_c    = last_c ? src_rem : LW'(BW);
    beat_dat  = '0;
    beat_keep = '0;
    for (int i = 0; i < BW; i++) begin
      if (LW'(i) < take_c) begin
        beat_keep[i] = 1'b1;
        beat_dat[8*i +: 8] = src_mode ? src_beat[8*i +: 8] : 8'(src_p + src_off + 8'(i));
      end
    end

    if (ld_beat) begin
      tvalid_d   = 1'b1;
      tdata_d    = beat_dat;
      tkeep_d    = beat_keep;
      tlast_d    = last_c;
      rem_d      = src_rem - take_c;
      off_d      = src_off + 8'(BW);
      run_beat_d = src_beat + DW'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      rem_q       <= '0;
      off_q       <= '0;
      run_beat_q  <= '0;
      gap_ctr_q   <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pkt_cnt_q   <= pkt_cnt_d;
      rem_q       <= rem_d;
      off_q       <= off_d;
      run_beat_q  <= run_beat_d;
      gap_ctr_q   <= gap_ctr_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pkt_cnt = pkt_cnt_q;
  assign tvalid  = tvalid_q;
  assign tdata   = tdata_q;
  assign tkeep   = tkeep_q;
  assign tlast   = tlast_q;

endmodule

// File: tb/tb_str_gen.sv
// Bench for str_gen: a packet-level model predicts every cycle's outputs,
// directed runs pin the model with literal beats, then randomized runs.
`define CHK(NM, ACT, EXP) begin n_cmp++; if ((ACT) !== (EXP)) begin n_err++; $display("FAIL %s: got %0h expected %0h at %0t", NM, ACT, EXP, $time); end end

module tb_str_gen;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int LW = 16;
  localparam int GW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_cnt = '0;
  logic          cfg_mode = 1'b0;
  logic          busy, done, tvalid, tlast;
  logic          tready = 1'b0;
  logic [CW-1:0] pkt_cnt;
  logic [DW-1:0] tdata;
  logic [BW-1:0] tkeep;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  str_gen #(.DW(DW), .LW(LW), .GW(GW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_cnt(cfg_cnt), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep), .tlast(tlast)
  );

  // Packet-level model state
  bit            m_busy = 1'b0, m_done = 1'b0, m_stop = 1'b0, m_mode = 1'b0;
  logic [CW-1:0] m_pkt = '0, m_cnt = '0;
  int            m_len = 1, m_gap = 0, m_idle = 0, m_bidx = 0;
  logic [31:0]   m_run = '0;
  int            n_done = 0, idle_cyc = 0;
  logic [DW-1:0] log_d[$];
  logic [BW-1:0] log_k[$];
  logic          log_l[$];

  // Compare process: outputs sampled mid-cycle, model advanced with the inputs the next edge will see.
  always @(negedge clk) begin : cmp
    logic [DW-1:0] e_d;
    logic [BW-1:0] e_k;
    logic          e_l, e_v;
    if (chk_on) begin
      e_d = '0;
      e_k = '0;
      for (int i = 0; i < BW; i++) begin
        int k;
        k = m_bidx * BW + i;
        if (k < m_len) begin
          e_k[i] = 1'b1;
          e_d[8*i +: 8] = m_mode ? m_run[8*i +: 8] : 8'(int'(m_pkt) + k);
        end
      end
      e_l = ((m_bidx + 1) * BW >= m_len);
      e_v = m_busy && (m_idle == 0);
      `CHK("busy", busy, m_busy)
      `CHK("done", done, m_done)
      `CHK("pkt_cnt", pkt_cnt, m_pkt)
      `CHK("tvalid", tvalid, e_v)
      if (e_v) begin
        `CHK("tdata", tdata, e_d)
        `CHK("tkeep", tkeep, e_k)
        `CHK("tlast", tlast, e_l)
      end
      if (done) n_done++;
      if (busy && !tvalid) idle_cyc++;
      if (tvalid && tready && !rst) begin
        log_d.push_back(tdata);
        log_k.push_back(tkeep);
        log_l.push_back(tlast);
      end
      m_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0; m_pkt = '0; m_idle = 0; m_stop = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_len  = (cfg_len == '0) ? 1 : int'(cfg_len);
          m_gap  = int'(cfg_gap);
          m_cnt  = cfg_cnt;
          m_mode = cfg_mode;
          m_pkt  = '0; m_bidx = 0; m_run = '0; m_idle = 0; m_stop = 1'b0;
        end
      end else if (m_idle != 0) begin
        if (stop) begin
          m_busy = 1'b0; m_done = 1'b1; m_idle = 0;
        end else begin
          m_idle--;
        end
      end else begin
        if (stop) m_stop = 1'b1;
        if (tready) begin
          m_run = m_run + 32'd1;
          if (e_l) begin
            m_pkt  = m_pkt + CW'(1);
            m_bidx = 0;
            if ((m_cnt != '0 && m_pkt == m_cnt) || m_stop) begin
              m_busy = 1'b0; m_done = 1'b1;
            end else begin
              m_idle = m_gap;
            end
          end else begin
            m_bidx++;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    log_d.delete();
    log_k.delete();
    log_l.delete();
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0  2 random.
  // smode: 0 none, 1 stop on a beat of packet spkt, 2 stop in the gap after packet spkt-1, 3 random.
  task automatic run(input int len, input int gap, input int cnt, input int mode,
                     input int rmode, input int smode, input int spkt, input bit scram);
    int cyc;
    bit sent;
    cfg_len  = LW'(len);
    cfg_gap  = GW'(gap);
    cfg_cnt  = CW'(cnt);
    cfg_mode = mode[0];
    start    = 1'b1;
    tick;
    start = 1'b0;
    cyc   = 0;
    sent  = 1'b0;
    while (busy) begin
      if (cyc >= 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL run_timeout: still busy after %0d cycles, required idle", cyc);
        break;
      end
      case (rmode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 3 == 0);
        default: tready = ($urandom_range(0, 9) < 7);
      endcase
      stop = 1'b0;
      if (smode == 1 && !sent && pkt_cnt == CW'(spkt) && tvalid) begin stop = 1'b1; sent = 1'b1; end
      if (smode == 2 && !sent && pkt_cnt == CW'(spkt) && !tvalid) begin stop = 1'b1; sent = 1'b1; end
      if (smode == 3) stop = ($urandom_range(0, 39) == 0);
      if (scram) begin
        cfg_len  = LW'($urandom_range(0, 60));
        cfg_gap  = GW'($urandom_range(0, 5));
        cfg_cnt  = CW'($urandom_range(0, 5));
        cfg_mode = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
      end
      tick;
      cyc++;
    end
    start  = 1'b0;
    stop   = 1'b0;
    tready = 1'b0;
    tick;
    tick;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nd0, id0;
    rst = 1'b1;
    tick;
    chk_on = 1'b1;
    tick;
    rst = 1'b0;
    `CHK("rst_tvalid", tvalid, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_tdata", tdata, 32'h0)
    `CHK("rst_pkt", pkt_cnt, 16'd0)

    // 10-byte single packet
    clr; nd0 = n_done;
    run(10, 0, 1, 0, 0, 0, 0, 1'b0);
    `CHK("t1_n", log_d.size(), 3)
    `CHK("t1_d0", log_d[0], 32'h03020100)
    `CHK("t1_d1", log_d[1], 32'h07060504)
    `CHK("t1_d2", log_d[2], 32'h00000908)
    `CHK("t1_k0", log_k[0], 4'hF)
    `CHK("t1_k2", log_k[2], 4'h3)
    `CHK("t1_l1", log_l[1], 1'b0)
    `CHK("t1_l2", log_l[2], 1'b1)
    `CHK("t1_pkt", pkt_cnt, 16'd1)
    `CHK("t1_done", n_done - nd0, 1)

    // back-to-back single-beat packets; stop alongside start is ignored
    clr; id0 = idle_cyc;
    stop = 1'b1;
    run(4, 0, 3, 0, 0, 0, 0, 1'b0);
    `CHK("t2_n", log_d.size(), 3)
    `CHK("t2_d0", log_d[0], 32'h03020100)
    `CHK("t2_d1", log_d[1], 32'h04030201)
    `CHK("t2_d2", log_d[2], 32'h05040302)
    `CHK("t2_l1", log_l[1], 1'b1)
    `CHK("t2_idle", idle_cyc - id0, 0)
    `CHK("t2_pkt", pkt_cnt, 16'd3)

    // beat counter with a 2-cycle gap
    clr; id0 = idle_cyc;
    run(8, 2, 2, 1, 0, 0, 0, 1'b0);
    `CHK("t3_n", log_d.size(), 4)
    `CHK("t3_d1", log_d[1], 32'd1)
    `CHK("t3_d2", log_d[2], 32'd2)
    `CHK("t3_d3", log_d[3], 32'd3)
    `CHK("t3_l1", log_l[1], 1'b1)
    `CHK("t3_idle", idle_cyc - id0, 2)

    // stalls with ready pattern 1,0,0
    clr;
    run(16, 0, 1, 0, 1, 0, 0, 1'b0);
    `CHK("t4_n", log_d.size(), 4)
    `CHK("t4_d1", log_d[1], 32'h07060504)
    `CHK("t4_d3", log_d[3], 32'h0F0E0D0C)

    // unlimited run, stop during packet 2
    clr; nd0 = n_done;
    run(12, 3, 0, 0, 0, 1, 2, 1'b0);
    `CHK("t5_pkt", pkt_cnt, 16'd3)
    `CHK("t5_n", log_d.size(), 9)
    `CHK("t5_d8", log_d[8], 32'h0D0C0B0A)
    `CHK("t5_l8", log_l[8], 1'b1)
    `CHK("t5_done", n_done - nd0, 1)

    // stop in the gap ends the run on the next edge
    clr; nd0 = n_done; id0 = idle_cyc;
    run(4, 5, 0, 0, 0, 2, 1, 1'b0);
    `CHK("t6_pkt", pkt_cnt, 16'd1)
    `CHK("t6_n", log_d.size(), 1)
    `CHK("t6_idle", idle_cyc - id0, 1)
    `CHK("t6_done", n_done - nd0, 1)

    // reset mid-beat while stalled
    nd0 = n_done;
    cfg_len = 16'd20; cfg_gap = 8'd0; cfg_cnt = 16'd1; cfg_mode = 1'b0;
    tready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    `CHK("t7_pre_tvalid", tvalid, 1'b1)
    rst = 1'b1;
    tick;
    rst = 1'b0;
    `CHK("t7_tvalid", tvalid, 1'b0)
    `CHK("t7_tdata", tdata, 32'h0)
    `CHK("t7_tkeep", tkeep, 4'h0)
    `CHK("t7_tlast", tlast, 1'b0)
    `CHK("t7_busy", busy, 1'b0)
    `CHK("t7_pkt", pkt_cnt, 16'd0)
    tick;
    `CHK("t7_nodone", n_done - nd0, 0)

    // zero length behaves as one byte
    clr;
    run(0, 0, 1, 0, 0, 0, 0, 1'b0);
    `CHK("t8_n", log_d.size(), 1)
    `CHK("t8_k", log_k[0], 4'h1)
    `CHK("t8_l", log_l[0], 1'b1)
    `CHK("t8_d", log_d[0], 32'h0)

    // randomized runs, config and start scrambled while busy
    for (int r = 0; r < 30; r++) begin
      int len, gap, cnt, mode, sm;
      len  = $urandom_range(0, 40);
      gap  = $urandom_range(0, 3);
      cnt  = $urandom_range(0, 4);
      mode = $urandom_range(0, 1);
      sm   = (cnt == 0 || $urandom_range(0, 3) == 0) ? 3 : 0;
      run(len, gap, cnt, mode, 2, sm, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/str_gen.md
Name: str_gen

Overview:
- Synthesizable stream traffic generator for the valid/ready stream bus. It is the parametrised successor of the single-transfer testbench stream source.
- Emits configurable packets with tlast/tkeep framing, deterministic data patterns, inter-packet idle gaps and packet-count limits.
- Drives DUT stream inputs in block-level and FPGA-level benches without a behavioural task layer.
- One clock; reset is synchronous and active-high.

Parameters:
- DW, 32, tdata width in bits; multiple of 8, minimum 8.
- BW, DW/8, byte-lane count, width of tkeep (derived; not overridden).
- LW, 16, width of cfg_len (packet length in bytes).
- GW, 8, width of cfg_gap (idle cycles between packets).
- CW, 16, width of cfg_cnt and pkt_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  launch a run; honoured only in IDLE.
- stop  input  1  graceful stop request; honoured only while busy.
- cfg_len  input  LW  packet length in bytes; 0 treated as 1.
- cfg_gap  input  GW  idle cycles (tvalid=0) between packets.
- cfg_cnt  input  CW  packets per run; 0 = unlimited until stop.
- cfg_mode  input  1  0 = byte ramp, 1 = beat counter.
- busy  output  1  high from the cycle after start until return to IDLE.
- done  output  1  one-cycle pulse on return to IDLE.
- pkt_cnt  output  CW  completed packets in the current/last run; wraps.
- tvalid  output  1  stream valid.
- tready  input  1  stream ready.
- tdata  output  DW  stream data, byte lane 0 = tdata[7:0].
- tkeep  output  BW  byte enables.
- tlast  output  1  last beat of packet.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0. rst mid-packet aborts at that edge; no done pulse.
- All outputs registered.
- cfg_* latched on the accepted start edge; changes while busy are ignored.
- pkt_cnt clears on the accepted start.
- start while busy: ignored.
- States: IDLE, SEND, GAP.
  - IDLE->SEND on start; tvalid=1 in the first cycle after the start edge.
  - SEND: a beat completes on an edge with tvalid&tready.
  - On completion of the tlast beat:
    - pkt_cnt+1.
    - If the run is finished (pkt_cnt reached cfg_cnt, or stop pending): ->IDLE, done=1 for one cycle, busy=0, tvalid=0.
    - Else if cfg_gap=0: stay in SEND, next packet's first beat presented the next cycle (back-to-back, no bubble).
    - Else: ->GAP.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND.
- Stop:
  - During SEND: latched as pending; the current packet finishes fully.
  - During GAP: ->IDLE on the next edge with done pulse.
  - stop together with start in IDLE: start taken, stop ignored.
- Stream rules:
  - Once tvalid=1, tdata/tkeep/tlast hold stable and tvalid stays 1 until accepted.
  - tready while tvalid=0 has no effect.
- Framing:
  - beats = ceil(L/BW), where L = max(cfg_len,1).
  - tkeep = all-ones on every beat except the last.
  - Last-beat tkeep = low (L mod BW) bits set, or all-ones if the remainder is 0.
  - Disabled bytes on tdata are driven 0.
- Data, mode 0 (byte ramp): byte k of packet p = (p + k) mod 256, where p is pkt_cnt at packet start.
- Data, mode 1 (beat counter): tdata = run-wide accepted-beat count, zero-extended/truncated to DW, starting at 0 per run; tkeep masking still applies.
- Unlimited mode: pkt_cnt wraps 2^CW-1 -> 0 without ending the run.

Test Plan:
- DW=32, cfg_len=10, cfg_cnt=1, mode0, tready=1 -> 3 beats:
  - 32'h03020100 keep 4'hF
  - 32'h07060504 keep 4'hF
  - 32'h00000908 keep 4'h3 tlast=1
  - then done pulse, pkt_cnt=1, busy=0.
- cfg_len=4, cfg_cnt=3, cfg_gap=0, mode0 -> 3 consecutive single-beat tlast packets with no bubble: 32'h03020100, 32'h04030201, 32'h05040302; pkt_cnt=3.
- cfg_len=8, cfg_gap=2, cfg_cnt=2, mode1 -> data 0,1, then exactly 2 cycles tvalid=0, then data 2,3.
- tready toggled 1,0,0,1,... during a mode0 packet -> tdata/tkeep/tlast stable across stalls; no beat lost or duplicated; order matches the ramp.
- cfg_cnt=0, stop asserted mid-packet 2 (cfg_len=12) -> packet 2 completes with tlast, done pulses, pkt_cnt=3; stop during GAP -> IDLE next edge.
- rst asserted mid-beat with tvalid=1, tready=0 -> next cycle all outputs 0, no done; cfg_len=0 run -> one beat, keep 4'h1, tlast=1.
